// File: rtl/dm_access_ctrl.sv
// Load/store initiator in front of `dm`; misaligned half/word accesses are split into byte beats.
// Define DM_MISALIGN_TRAP_EN to trap misaligned accesses (resp_err, no memory beats) instead of splitting.
module dm_access_ctrl #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_type,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic          stall,
    output logic          DMWr,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] din,
    output logic [2:0]    DMType,
    input  logic [DW-1:0] dout
);
    localparam logic [2:0] T_WORD  = 3'b000;
    localparam logic [2:0] T_HALF  = 3'b001;
    localparam logic [2:0] T_HALFU = 3'b010;
    localparam logic [2:0] T_BYTEU = 3'b100;

    typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;

    function automatic logic misaligned(input logic [2:0] t, input logic [1:0] a);
        return ((t == T_HALF || t == T_HALFU) && a[0]) || (t == T_WORD && a != 2'b00);
    endfunction

    function automatic logic illegal(input logic [2:0] t);
        return t > T_BYTEU;
    endfunction

    state_t        state;
    logic          we_q;
    logic [2:0]    type_q;
    logic          split_q;
    logic          illegal_q;
    logic [1:0]    beat_cnt;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] asm_q;
    logic [DW-1:0] asm_next;
    logic [DW-1:0] load_data;
    logic          req_mis;
    logic          req_ill;
    logic          is_last;

    assign req_mis = misaligned(req_type, req_addr[1:0]);
    assign req_ill = illegal(req_type);
    assign is_last = !split_q || (beat_cnt == ((type_q == T_WORD) ? 2'd3 : 2'd1));

    always_comb begin
        // NOTE: every variable gets a value before any condition so no latch is inferred.
        asm_next  = asm_q;
        asm_next[{beat_cnt, 3'b000} +: 8] = dout[7:0];
        load_data = asm_next;
        if (!split_q) begin
            load_data = dout;
        end else if (type_q == T_HALF) begin
            load_data = {{(DW-16){asm_next[15]}}, asm_next[15:0]};
        end else if (type_q == T_HALFU) begin
            load_data = {{(DW-16){1'b0}}, asm_next[15:0]};
        end
    end

    // NOTE: state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            stall      <= 1'b0;
            DMWr       <= 1'b0;
            addr       <= '0;
            din        <= '0;
            DMType     <= '0;
            we_q       <= 1'b0;
            type_q     <= '0;
            split_q    <= 1'b0;
            illegal_q  <= 1'b0;
            beat_cnt   <= '0;
            wdata_q    <= '0;
            asm_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        type_q    <= req_type;
                        split_q   <= req_mis;
                        illegal_q <= req_ill;
                        wdata_q   <= {8'h00, req_wdata[DW-1:8]};
                        beat_cnt  <= '0;
                        req_ready <= 1'b0;
                        stall     <= 1'b1;
`ifdef DM_MISALIGN_TRAP_EN
                        if (req_mis) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else
`endif
                        begin
                            state <= BEAT;
                            DMWr  <= req_we && !req_ill;
                            addr  <= req_addr;
                            if (req_mis) begin
                                DMType <= T_BYTEU;
                                din    <= {{(DW-8){1'b0}}, req_wdata[7:0]};
                            end else begin
                                DMType <= req_type;
                                din    <= req_wdata;
                            end
                        end
                    end
                end
                BEAT: begin
                    if (split_q) begin
                        asm_q <= asm_next;
                    end
                    if (is_last) begin
                        state      <= RESP;
                        DMWr       <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= illegal_q;
                        resp_rdata <= (we_q || illegal_q) ? '0 : load_data;
                    end else begin
                        // Store bytes leave the shift register LSB first, one per beat.
                        beat_cnt <= beat_cnt + 2'd1;
                        addr     <= addr + AW'(1);
                        din      <= {{(DW-8){1'b0}}, wdata_q[7:0]};
                        wdata_q  <= {8'h00, wdata_q[DW-1:8]};
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    stall      <= 1'b0;
                    req_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
